led_scan_driver: RTL and testbench
==================================

// Module: led_scan_driver
// PURPOSE
//  Downstream stage of the LED lookup block. Takes its 4-bit digit-enable mask and 8-bit
//  segment pattern, time-multiplexes them onto a 4-digit common-anode display, and inserts
//  blanking between digits to suppress ghosting. Inputs are snapshotted once per frame, so
//  a mid-frame change never tears the displayed image.
// PARAMETERS
//  NDIG      4    number of digits scanned, 1..8
//  DIV       50000 clocks per digit slot, >= BLANK_CYC+1
//  BLANK_CYC 500  clocks at the start of each slot with all anodes off, >= 1
//  SEG_AL    1    1 = segments active-low at the pins (pattern inverted), 0 = active-high
// PORTS
//  iclk        in   1     system clock, all logic on rising edge
//  irst_n      in   1     asynchronous active-low reset
//  led_sel     in   NDIG  digit-enable mask from upstream, bit i=1 lights digit i
//  lut_out     in   8     segment pattern from upstream, bit=1 lights segment
//  an          out  NDIG  anode drives, active-low
//  seg         out  8     segment drives, polarity per SEG_AL
//  frame_tick  out  1     1-cycle pulse on the first cycle of each frame (digit 0 slot)
// BEHAVIOUR
//  Reset (async, irst_n=0): an = all 1s; seg = all-off (8'hFF if SEG_AL, else 8'h00);
//   frame_tick=0; shadow regs cleared to 0; digit idx=0; slot cnt=0; state=BLANK.
//   Outputs go off immediately on assertion. First frame starts on the first edge after release.
//  Slot counter 0..DIV-1, wraps. On wrap, idx increments; NDIG-1 wraps to 0.
//  FSM per slot: BLANK (cnt 0..BLANK_CYC-1) -> DRIVE (cnt BLANK_CYC..DIV-1) -> BLANK of next slot.
//  BLANK: an all 1s, seg all-off.
//  DRIVE: an[idx]=0 only if sh_sel[idx]=1; other anodes stay 1. seg=sh_pat (inverted if SEG_AL).
//  Snapshot: on cnt==0 && idx==0, sh_sel<=led_sel and sh_pat<=lut_out; frame_tick=1 that cycle.
//  Latency: input change -> pins within one frame + BLANK_CYC (worst case NDIG*DIV+BLANK_CYC clocks).
//  A disabled digit still uses its full slot, so the refresh rate is independent of the mask.
//  Upstream reset pattern (sel=all 1s, pat=8'hFF) yields all segments on all digits (lamp test).
//  An all-zero mask or pattern displays dark but continues scanning and ticking.
//  All outputs are registered: no combinational path from inputs to pins.
//  Parameter violations (DIV<=BLANK_CYC, BLANK_CYC<1, NDIG outside 1..8) are an elaboration error.
// CONFIGURATION
//  LED_SCAN_PWM_EN defined: adds input ibright[3:0], snapshotted with sh_sel. A free-running
//   4-bit pwm counter runs; during DRIVE, an[idx] asserts only while pwm_cnt < sh_bright.
//   0 = dark, 15 = 15/16 duty. Reset: pwm_cnt=0, sh_bright=0.
//  Not defined: no ibright port; DRIVE asserts the anode for the full DRIVE phase (100% duty).
// STRUCTURE
//  led_pkg: NDIG_MAX, state enum {ST_BLANK, ST_DRIVE}, SEG_OFF constant, seg_pol() function.
//  Sub-module led_slot_timer: slot counter + digit idx + frame_tick (wrap logic in one place).
//  Top: snapshot regs, FSM decode, optional PWM, output regs.
// TESTING  (DIV=8, BLANK_CYC=2, NDIG=4, SEG_AL=1)
//  1 Reset held, then released with sel=4'hF, pat=8'hFF: an=4'hF and seg=8'hFF during reset;
//    frame_tick on the first edge; after 2 clks an=4'b1110 and seg=8'h00, for 6 clks.
//  2 sel=4'b0111, pat=8'h41: digits 0-2 show seg=8'hBE in turn; slot 3 keeps an=4'hF for all
//    8 clks; frame_tick period is 32 clks.
//  3 Change pat 8'h41->8'h01 mid-frame (clk 13): seg stays 8'hBE until the next frame's DRIVE,
//    then becomes 8'hFE.
//  4 Assert irst_n=0 mid-DRIVE: an=4'hF and seg=8'hFF before the next edge. Release: scan
//    restarts at digit 0.
//  5 Every slot: exactly 2 clks with an=4'hF before any anode asserts; never 2 anodes low at once.
//  6 LED_SCAN_PWM_EN, ibright=4'd8: per lit digit, anode low for exactly those DRIVE cycles with
//    pwm_cnt<8. ibright=0: an stays 4'hF.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types, constants and helpers for led_scan_driver and led_slot_timer.
package led_pkg;

    localparam int NDIG_MAX = 8;

    // Logical "nothing lit" pattern, before pin polarity is applied.
    localparam logic [7:0] SEG_OFF = 8'h00;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_e;

    function automatic logic [7:0] seg_pol(input logic [7:0] pat, input logic active_low);
        return active_low ? ~pat : pat;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_slot_timer.sv
// Slot counter (0..DIV-1), digit index (0..NDIG-1) and the registered per-frame tick.
module led_slot_timer
    import led_pkg::*;
#(
    parameter  int NDIG  = 4,
    parameter  int DIV   = 50000,
    localparam int CNT_W = $clog2(DIV),
    localparam int IDX_W = idx_width(NDIG)
) (
    input  logic             iclk,
    input  logic             irst_n,
    output logic [CNT_W-1:0] o_cnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_frame_start,
    output logic             o_frame_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_frame_tick;

    assign o_frame_start = (r_cnt == '0) && (r_idx == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= o_frame_start;
            if (r_cnt == CNT_W'(DIV - 1)) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cnt        = r_cnt;
    assign o_idx        = r_idx;
    assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/led_scan_driver.sv
// Snapshots mask/pattern once per frame and scans them onto NDIG common-anode digits with
// inter-digit blanking. Optional brightness PWM enabled by defining LED_SCAN_PWM_EN.
module led_scan_driver
    import led_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 500,
    parameter int SEG_AL    = 1
) (
    input  logic            iclk,
    input  logic            irst_n,
    input  logic [NDIG-1:0] led_sel,
    input  logic [7:0]      lut_out,
`ifdef LED_SCAN_PWM_EN
    input  logic [3:0]      ibright,
`endif
    output logic [NDIG-1:0] an,
    output logic [7:0]      seg,
    output logic            frame_tick
);

    localparam int         CNT_W    = $clog2(DIV);
    localparam int         IDX_W    = idx_width(NDIG);
    localparam logic [7:0] SEG_IDLE = seg_pol(SEG_OFF, SEG_AL != 0);

    if (NDIG < 1 || NDIG > NDIG_MAX) begin : g_bad_ndig
        $error("led_scan_driver: NDIG=%0d outside 1..%0d", NDIG, NDIG_MAX);
    end
    if (BLANK_CYC < 1) begin : g_bad_blank
        $error("led_scan_driver: BLANK_CYC=%0d must be >= 1", BLANK_CYC);
    end
    if (DIV <= BLANK_CYC) begin : g_bad_div
        $error("led_scan_driver: DIV=%0d must exceed BLANK_CYC=%0d", DIV, BLANK_CYC);
    end

    logic [CNT_W-1:0] w_cnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_frame_start;
    logic [NDIG-1:0]  r_sh_sel;
    logic [7:0]       r_sh_pat;
    state_e           r_state;
    state_e           w_state_nxt;
    logic [NDIG-1:0]  w_dig_onehot;
    logic [NDIG-1:0]  w_an_nxt;
    logic [NDIG-1:0]  r_an;
    logic [7:0]       w_seg_nxt;
    logic [7:0]       r_seg;
    logic             w_pwm_on;

    led_slot_timer #(
        .NDIG (NDIG),
        .DIV  (DIV)
    ) u_timer (
        .iclk          (iclk),
        .irst_n        (irst_n),
        .o_cnt         (w_cnt),
        .o_idx         (w_idx),
        .o_frame_start (w_frame_start),
        .o_frame_tick  (frame_tick)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_sh_sel <= '0;
            r_sh_pat <= '0;
        end else if (w_frame_start) begin
            r_sh_sel <= led_sel;
            r_sh_pat <= lut_out;
        end
    end

`ifdef LED_SCAN_PWM_EN
    logic [3:0] r_pwm_cnt;
    logic [3:0] r_sh_bright;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_pwm_cnt   <= '0;
            r_sh_bright <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            if (w_frame_start) begin
                r_sh_bright <= ibright;
            end
        end
    end

    assign w_pwm_on = (r_pwm_cnt < r_sh_bright);
`else
    assign w_pwm_on = 1'b1;
`endif

    assign w_dig_onehot = NDIG'(1) << w_idx;

    // The slot position in w_cnt is the one the registered outputs will show after this edge.
    // NOTE: every signal written here gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = '1;
        w_seg_nxt   = SEG_IDLE;
        case (r_state)
            ST_BLANK: if (w_cnt == CNT_W'(BLANK_CYC)) w_state_nxt = ST_DRIVE;
            ST_DRIVE: if (w_cnt == '0)                w_state_nxt = ST_BLANK;
            default:  w_state_nxt = ST_BLANK;
        endcase
        if (w_state_nxt == ST_DRIVE) begin
            w_an_nxt  = ~(r_sh_sel & w_dig_onehot & {NDIG{w_pwm_on}});
            w_seg_nxt = seg_pol(r_sh_pat, SEG_AL != 0);
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= ST_BLANK;
            r_an    <= '1;
            r_seg   <= SEG_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_led_scan_driver.sv
// Self-checking bench for led_scan_driver (NDIG=4, DIV=8, BLANK_CYC=2, SEG_AL=1).
// Model: frame position from edge count since reset release; snapshot at each frame start.
module tb_led_scan_driver;

    localparam int NDIG      = 4;
    localparam int DIV       = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = NDIG * DIV;

    logic       iclk;
    logic       irst_n;
    logic [3:0] led_sel;
    logic [7:0] lut_out;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame_tick;
`ifdef LED_SCAN_PWM_EN
    logic [3:0] ibright;
    logic [3:0] m_bright;
`endif

    int         checks = 0;
    int         errors = 0;
    int         k;
    logic [3:0] m_sel;
    logic [7:0] m_pat;

    led_scan_driver #(
        .NDIG      (NDIG),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC),
        .SEG_AL    (1)
    ) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .led_sel    (led_sel),
        .lut_out    (lut_out),
`ifdef LED_SCAN_PWM_EN
        .ibright    (ibright),
`endif
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, "_an"},   32'(an),         32'h0000_000F);
        check({tag, "_seg"},  32'(seg),        32'h0000_00FF);
        check({tag, "_tick"}, 32'(frame_tick), 32'd0);
    endtask

    // Expected pins for the k-th edge since release, from frame/slot arithmetic.
    task automatic check_outputs();
        int         p;
        int         d;
        int         s;
        logic       lit;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        p     = (k - 1) % FRAME;
        d     = p / DIV;
        s     = p % DIV;
        e_an  = 4'hF;
        e_seg = 8'hFF;
        if (s >= BLANK_CYC) begin
            lit = m_sel[d];
`ifdef LED_SCAN_PWM_EN
            lit = lit && (((k - 1) % 16) < int'(m_bright));
`endif
            if (lit) e_an[d] = 1'b0;
            e_seg = ~m_pat;
        end
        check("frame_tick", 32'(frame_tick), 32'(p == 0));
        check("an",         32'(an),         32'(e_an));
        check("seg",        32'(seg),        32'(e_seg));
        check("one_anode",  32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iclk);
            k++;
            if ((k - 1) % FRAME == 0) begin
                m_sel = led_sel;
                m_pat = lut_out;
`ifdef LED_SCAN_PWM_EN
                m_bright = ibright;
`endif
            end
            @(negedge iclk);
            check_outputs();
        end
    endtask

    task automatic reset_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iclk);
            check_off("in_reset");
        end
    endtask

    task automatic model_reset();
        k     = 0;
        m_sel = '0;
        m_pat = '0;
`ifdef LED_SCAN_PWM_EN
        m_bright = '0;
`endif
    endtask

    initial begin
        irst_n  = 1'b1;
        led_sel = 4'hF;
        lut_out = 8'hFF;
`ifdef LED_SCAN_PWM_EN
        ibright = 4'd8;
`endif
        model_reset();

        // Lamp-test pattern through reset and release.
        #2 irst_n = 1'b0;
        #1 check_off("async_rst");
        reset_hold(3);
        irst_n = 1'b1;
        run(2 * FRAME);

        // Digit 3 masked; pattern changes at clk 13 and must wait for the next frame.
        led_sel = 4'b0111;
        lut_out = 8'h41;
        run(13);
        lut_out = 8'h01;
        run(2 * FRAME - 13);

        // Randomized inputs changing at arbitrary points within frames.
        for (int i = 0; i < 12; i++) begin
            led_sel = 4'($urandom);
            lut_out = 8'($urandom);
`ifdef LED_SCAN_PWM_EN
            ibright = 4'($urandom);
`endif
            run($urandom_range(4, 40));
        end

        // Dark mask, then dark pattern: scanning and ticking continue.
        led_sel = 4'h0;
        lut_out = 8'hFF;
        run(FRAME);
        led_sel = 4'hF;
        lut_out = 8'h00;
        run(FRAME);

        // Reset mid-DRIVE of digit 0: outputs drop before the next edge, scan restarts.
        led_sel = 4'hF;
        lut_out = 8'h5A;
`ifdef LED_SCAN_PWM_EN
        ibright = 4'd15;
`endif
        run(FRAME - (k % FRAME));
        run(BLANK_CYC + 2);
        irst_n = 1'b0;
        #1 check_off("mid_drive_rst");
        model_reset();
        reset_hold(2);
        irst_n = 1'b1;
        run(FRAME + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
